// File: rtl/pmp_req_arbiter.sv
// Purpose : arbitrates fetch and load/store PMP check requests onto one shared
//           checker. LSU has fixed priority, and a starving fetch gets priority
//           once it has waited STARVE_LIMIT cycles.
// Latency : 1 cycle. The request is accepted and checked in cycle N, and the
//           response is valid in cycle N+1.
// Backpressure: one response slot. A new request is granted only in IDLE, or in
//           the cycle the pending response is taken (resp_ready=1), so full
//           throughput is one response per cycle.
//
// Ports:
//   clk, rst                                : clock and synchronous active-high reset
//   if_req_valid/if_req_ready/if_addr       : fetch request (size 2'b10, oper X = 2'b10)
//   lsu_req_valid/lsu_req_ready/lsu_addr,
//   lsu_size, lsu_we                        : load/store request (oper 2'b01 store, 2'b00 load)
//   priv_mode                               : privilege, forwarded on chk_priv
//   chk_addr/chk_size/chk_oper/chk_priv     : drive the shared checker (zero when there is no grant)
//   chk_perm                                : checker result, 2'b11 = allowed
//   resp_valid/resp_ready/resp_id,
//   resp_fault/resp_cause                   : response (id 0 = fetch, 1 = LSU)
// Optional: define PMP_FAULT_LATCH_EN to add the fault_valid/fault_addr/fault_clear
//   sticky first-fault capture.
module pmp_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_we,
  input  logic [1:0]  priv_mode,
  output logic [31:0] chk_addr,
  output logic [1:0]  chk_size,
  output logic [1:0]  chk_oper,
  output logic [1:0]  chk_priv,
  input  logic [1:0]  chk_perm,
`ifdef PMP_FAULT_LATCH_EN
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  input  logic        fault_clear,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic        resp_fault,
  output logic [1:0]  resp_cause
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic        resp_fault_q, resp_fault_d;
  logic [1:0]  resp_cause_q, resp_cause_d;
`ifdef PMP_FAULT_LATCH_EN
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;
`endif

  logic can_grant;
  logic grant_if;
  logic grant_lsu;
  logic grant;
  logic perm_fault;

  // Grant selection and checker drive
  always_comb begin
    // The response slot is free when idle, or when it drains this very cycle.
    can_grant = !rst && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    grant_if  = can_grant && if_req_valid &&
                ((starve_q == STARVE_MAX) || !lsu_req_valid);
    grant_lsu = can_grant && lsu_req_valid && !grant_if;
    grant     = grant_if || grant_lsu;

    chk_addr = 32'h0;
    chk_size = 2'b00;
    chk_oper = 2'b00;
    chk_priv = 2'b00;
    if (grant_if) begin
      chk_addr = if_addr;
      chk_size = 2'b10;
      chk_oper = 2'b10;
      chk_priv = priv_mode;
    end else if (grant_lsu) begin
      chk_addr = lsu_addr;
      chk_size = lsu_size;
      chk_oper = {1'b0, lsu_we};
      chk_priv = priv_mode;
    end

    perm_fault = (chk_perm != 2'b11);
  end

  // Next-state logic
  always_comb begin
    // The counter stops at the limit. Stopping there keeps the equality test
    // true for as long as fetch stays blocked, even across long response stalls.
    if (!if_req_valid || grant_if) begin
      starve_d = 3'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 3'd1;
    end else begin
      starve_d = starve_q;
    end

    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;
    if (grant) begin
      state_d      = RESP;
      resp_valid_d = 1'b1;
      resp_id_d    = grant_lsu;
      resp_fault_d = perm_fault;
      resp_cause_d = chk_perm;
    end else if ((state_q == RESP) && resp_ready) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
    end

`ifdef PMP_FAULT_LATCH_EN
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    if (fault_clear) begin
      fault_valid_d = 1'b0;
    end
    // A fault arriving together with the clear wins over the clear.
    if (grant && perm_fault && (!fault_valid_q || fault_clear)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = chk_addr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_q      <= 3'd0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_cause_q  <= 2'b00;
`ifdef PMP_FAULT_LATCH_EN
      fault_valid_q <= 1'b0;
      fault_addr_q  <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_fault_q  <= resp_fault_d;
      resp_cause_q  <= resp_cause_d;
`ifdef PMP_FAULT_LATCH_EN
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
`endif
    end
  end

  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_fault    = resp_fault_q;
  assign resp_cause    = resp_cause_q;
`ifdef PMP_FAULT_LATCH_EN
  assign fault_valid   = fault_valid_q;
  assign fault_addr    = fault_addr_q;
`endif

endmodule

// File: doc/pmp_req_arbiter.md
PMP_REQ_ARBITER -- requirements
Module: pmp_req_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive cycles a blocked fetch request waits before it wins arbitration (range 1..7).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port if_req_valid, input, 1: fetch check request.
REQ-005 SHALL have port if_req_ready, output, 1: fetch request accepted this cycle.
REQ-006 SHALL have port if_addr, input, 32: fetch address; size fixed 2'b10, oper fixed 2'b10 (X).
REQ-007 SHALL have port lsu_req_valid, input, 1: load/store check request.
REQ-008 SHALL have port lsu_req_ready, output, 1: load/store request accepted this cycle.
REQ-009 SHALL have port lsu_addr, input, 32: load/store address.
REQ-010 SHALL have port lsu_size, input, 2: access size, same encoding as the checker.
REQ-011 SHALL have port lsu_we, input, 1: 1 = store (oper 2'b01), 0 = load (oper 2'b00).
REQ-012 SHALL have port priv_mode, input, 2: current privilege, forwarded to the checker.
REQ-013 SHALL have ports chk_addr (32), chk_size (2), chk_oper (2) and chk_priv (2), all outputs: drive the shared PMP checker.
REQ-014 SHALL have port chk_perm, input, 2: checker result; 2'b11 = allowed, any other value = fault code.
REQ-015 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-016 SHALL have port resp_id, output, 1: 0 = fetch, 1 = LSU.
REQ-017 SHALL have ports resp_fault (output, 1) and resp_cause (output, 2): fault flag and the registered chk_perm value.

Function
REQ-018 Grant SHALL be issued only when the FSM is in IDLE, or in RESP with resp_ready=1.
REQ-019 Arbitration SHALL be fixed-priority LSU over fetch. When starve_cnt equals STARVE_LIMIT and if_req_valid=1, fetch SHALL win instead.
REQ-020 starve_cnt (3 bits) SHALL increment, saturating, each cycle if_req_valid=1 and fetch is not granted. It SHALL clear on a fetch grant or when if_req_valid=0.
REQ-021 Exactly one of if_req_ready/lsu_req_ready SHALL be high in a grant cycle, and both SHALL be low otherwise.
REQ-022 chk_* SHALL present the granted request combinationally in the grant cycle. They SHALL be driven to zero when there is no grant.
REQ-023 chk_perm SHALL be registered into the response stage at the end of the grant cycle, so resp_valid rises one cycle after request acceptance (latency 1).
REQ-024 resp_fault SHALL be (registered chk_perm != 2'b11), and resp_cause SHALL equal the registered chk_perm.
REQ-025 The FSM SHALL have states IDLE and RESP: IDLE->RESP on grant; RESP->RESP on resp_ready with a new grant; RESP->IDLE on resp_ready with no grant; RESP holds while resp_ready=0.
REQ-026 resp_valid, resp_id, resp_fault and resp_cause SHALL remain stable while resp_valid=1 and resp_ready=0.
REQ-027 Back-to-back accepted requests SHALL sustain one response per cycle when resp_ready is held at 1.

Reset
REQ-028 On rst=1 at a clock edge, the FSM SHALL go to IDLE, starve_cnt to 0, and resp_valid, resp_id, resp_fault, resp_cause and fault_valid to 0, with fault_addr set to 32'h0.
REQ-029 A reset asserted mid-response SHALL drop the pending response with no handshake. Both req_ready outputs SHALL be 0 while rst=1.

Configuration
REQ-030 Macro PMP_FAULT_LATCH_EN, when defined, SHALL add output fault_valid (1), output fault_addr (32) and input fault_clear (1).
REQ-031 With the macro defined, the first faulting response SHALL set fault_valid and capture its address. Later faults SHALL NOT overwrite it until fault_clear=1. If fault_clear and a new fault occur in the same cycle, the new fault SHALL be captured.
REQ-032 Without the macro, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Both requests valid, starve_cnt=0, chk_perm=2'b11 -> lsu_req_ready=1; next cycle resp_valid=1, resp_id=1, resp_fault=0.
REQ-034 LSU valid continuously, fetch valid, STARVE_LIMIT=3 -> fetch is granted on the 4th cycle, and starve_cnt then reads 0.
REQ-035 Store to 32'h8000_0010 with chk_perm=2'b01 -> resp_fault=1 and resp_cause=2'b01; with the macro defined, fault_addr=32'h8000_0010.
REQ-036 resp_ready=0 for 3 cycles with a new LSU request pending -> lsu_req_ready=0 and the response is held stable; on resp_ready=1 the new grant occurs in the same cycle.
REQ-037 rst=1 asserted during RESP -> next cycle resp_valid=0, FSM in IDLE, starve_cnt=0.
REQ-038 Macro defined: two successive faults at 32'h100 then 32'h200 -> fault_addr=32'h100; after fault_clear, a fault at 32'h300 -> fault_addr=32'h300.
